// File: rtl/sudoku_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sudoku_entry_ctrl
// Description : Session sequencer for a 4x4 Sudoku game. It walks through
//               difficulty select, board-setup intake from the generator,
//               row/col/value move entry and the solution-check handshake.
//               It owns the fixed-cell mask and the per-cell fill flags, and
//               issues single-cycle write commands to the user-board storage.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   in_clka            clock, rising edge
//   in_restart_n       asynchronous active-low reset
//   in_new_game        start / abort a game (highest priority)
//   in_enter           one-cycle confirm pulse for the current field
//   in_diff_cell_val   difficulty / row / col / value-minus-1 selector
//   in_load_valid      generator setup write strobe
//   in_load_idx        setup cell index
//   in_load_val        setup value, 0 = empty
//   in_load_done       generator finished setup
//   in_check_done      checker result valid
//   in_check_pass      checker result, qualified by in_check_done
//   out_state          current state encoding
//   out_*_flag         high while in SET_DIFF / ROW / COL / VAL / CHECK
//   out_diff           latched difficulty
//   out_wr_en          user-board write strobe
//   out_wr_idx         write index (row*4+col)
//   out_wr_val         write value 1..4
//   out_fill_flag      bit i set when cell i holds a value
//   out_reject         one-cycle pulse: move refused or check timed out
//   out_solved         game solved
//   out_move_cnt       saturating count of accepted user moves
// ============================================================================
module sudoku_entry_ctrl #(
    parameter int MOVE_W   = 8,
    parameter int CHECK_TO = 15
) (
    input  logic              in_clka,
    input  logic              in_restart_n,
    input  logic              in_new_game,
    input  logic              in_enter,
    input  logic [1:0]        in_diff_cell_val,
    input  logic              in_load_valid,
    input  logic [3:0]        in_load_idx,
    input  logic [2:0]        in_load_val,
    input  logic              in_load_done,
    input  logic              in_check_done,
    input  logic              in_check_pass,
    output logic [3:0]        out_state,
    output logic              out_set_diff_flag,
    output logic              out_row_flag,
    output logic              out_col_flag,
    output logic              out_val_flag,
    output logic              out_check_flag,
    output logic [1:0]        out_diff,
    output logic              out_wr_en,
    output logic [3:0]        out_wr_idx,
    output logic [2:0]        out_wr_val,
    output logic [15:0]       out_fill_flag,
    output logic              out_reject,
    output logic              out_solved,
    output logic [MOVE_W-1:0] out_move_cnt
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_SET_DIFF  = 4'd1,
        ST_WAIT_LOAD = 4'd2,
        ST_ROW       = 4'd3,
        ST_COL       = 4'd4,
        ST_VAL       = 4'd5,
        ST_WRITE     = 4'd6,
        ST_CHECK     = 4'd7,
        ST_SOLVED    = 4'd8
    } state_t;

    localparam logic [15:0]       c_FULL     = 16'hFFFF;
    localparam logic [7:0]        c_CHECK_TO = 8'(CHECK_TO);
    localparam logic [MOVE_W-1:0] c_MOVE_MAX = {MOVE_W{1'b1}};

    state_t              state_q, state_d;
    logic [1:0]          diff_q, diff_d;
    logic [1:0]          row_q, row_d;
    logic [1:0]          col_q, col_d;
    logic [15:0]         fixed_q, fixed_d;
    logic [15:0]         fill_q, fill_d;
    logic [MOVE_W-1:0]   move_cnt_q, move_cnt_d;
    logic [7:0]          timer_q, timer_d;
    logic                wr_en_q, wr_en_d;
    logic [3:0]          wr_idx_q, wr_idx_d;
    logic [2:0]          wr_val_q, wr_val_d;
    logic                reject_q, reject_d;
    logic                solved_q, solved_d;
    logic                set_diff_flag_q, set_diff_flag_d;
    logic                row_flag_q, row_flag_d;
    logic                col_flag_q, col_flag_d;
    logic                val_flag_q, val_flag_d;
    logic                check_flag_q, check_flag_d;

    logic [3:0]          w_cell_idx;

    assign w_cell_idx = {row_q, col_q};

    always_comb begin
        state_d    = state_q;
        diff_d     = diff_q;
        row_d      = row_q;
        col_d      = col_q;
        fixed_d    = fixed_q;
        fill_d     = fill_q;
        move_cnt_d = move_cnt_q;
        wr_idx_d   = wr_idx_q;
        wr_val_d   = wr_val_q;
        solved_d   = solved_q;
        wr_en_d    = 1'b0;
        reject_d   = 1'b0;
        // Free-running while in CHECK, so it reads 0 on the first CHECK cycle.
        timer_d    = (state_q == ST_CHECK) ? timer_q + 8'd1 : 8'd0;

        if (in_new_game) begin
            state_d    = ST_SET_DIFF;
            move_cnt_d = '0;
            fill_d     = '0;
            fixed_d    = '0;
            solved_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_SET_DIFF: begin
                    if (in_enter) begin
                        diff_d  = in_diff_cell_val;
                        state_d = ST_WAIT_LOAD;
                    end
                end
                ST_WAIT_LOAD: begin
                    // A write arriving together with done is still applied.
                    if (in_load_valid) begin
                        fixed_d[in_load_idx] = (in_load_val != 3'd0);
                        fill_d[in_load_idx]  = (in_load_val != 3'd0);
                    end
                    if (in_load_done) begin
                        state_d = ST_ROW;
                    end
                end
                ST_ROW: begin
                    if (in_enter) begin
                        row_d   = in_diff_cell_val;
                        state_d = ST_COL;
                    end
                end
                ST_COL: begin
                    if (in_enter) begin
                        col_d   = in_diff_cell_val;
                        state_d = ST_VAL;
                    end
                end
                ST_VAL: begin
                    if (in_enter) begin
                        if (fixed_q[w_cell_idx]) begin
                            reject_d = 1'b1;
                            state_d  = ST_ROW;
                        end else begin
                            wr_en_d  = 1'b1;
                            wr_idx_d = w_cell_idx;
                            wr_val_d = {1'b0, in_diff_cell_val} + 3'd1;
                            state_d  = ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    fill_d[wr_idx_q] = 1'b1;
                    if (move_cnt_q != c_MOVE_MAX) begin
                        move_cnt_d = move_cnt_q + MOVE_W'(1);
                    end
                    // Decide on the board including this write.
                    state_d = (fill_d == c_FULL) ? ST_CHECK : ST_ROW;
                end
                ST_CHECK: begin
                    // A result on the timeout cycle takes precedence.
                    if (in_check_done) begin
                        if (in_check_pass) begin
                            solved_d = 1'b1;
                            state_d  = ST_SOLVED;
                        end else begin
                            state_d  = ST_ROW;
                        end
                    end else if (timer_q == c_CHECK_TO) begin
                        reject_d = 1'b1;
                        state_d  = ST_ROW;
                    end
                end
                ST_SOLVED: begin
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        set_diff_flag_d = (state_d == ST_SET_DIFF);
        row_flag_d      = (state_d == ST_ROW);
        col_flag_d      = (state_d == ST_COL);
        val_flag_d      = (state_d == ST_VAL);
        check_flag_d    = (state_d == ST_CHECK);
    end

    always_ff @(posedge in_clka or negedge in_restart_n) begin
        if (!in_restart_n) begin
            state_q         <= ST_IDLE;
            diff_q          <= '0;
            row_q           <= '0;
            col_q           <= '0;
            fixed_q         <= '0;
            fill_q          <= '0;
            move_cnt_q      <= '0;
            timer_q         <= '0;
            wr_en_q         <= 1'b0;
            wr_idx_q        <= '0;
            wr_val_q        <= '0;
            reject_q        <= 1'b0;
            solved_q        <= 1'b0;
            set_diff_flag_q <= 1'b0;
            row_flag_q      <= 1'b0;
            col_flag_q      <= 1'b0;
            val_flag_q      <= 1'b0;
            check_flag_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            diff_q          <= diff_d;
            row_q           <= row_d;
            col_q           <= col_d;
            fixed_q         <= fixed_d;
            fill_q          <= fill_d;
            move_cnt_q      <= move_cnt_d;
            timer_q         <= timer_d;
            wr_en_q         <= wr_en_d;
            wr_idx_q        <= wr_idx_d;
            wr_val_q        <= wr_val_d;
            reject_q        <= reject_d;
            solved_q        <= solved_d;
            set_diff_flag_q <= set_diff_flag_d;
            row_flag_q      <= row_flag_d;
            col_flag_q      <= col_flag_d;
            val_flag_q      <= val_flag_d;
            check_flag_q    <= check_flag_d;
        end
    end

    assign out_state         = state_q;
    assign out_set_diff_flag = set_diff_flag_q;
    assign out_row_flag      = row_flag_q;
    assign out_col_flag      = col_flag_q;
    assign out_val_flag      = val_flag_q;
    assign out_check_flag    = check_flag_q;
    assign out_diff          = diff_q;
    assign out_wr_en         = wr_en_q;
    assign out_wr_idx        = wr_idx_q;
    assign out_wr_val        = wr_val_q;
    assign out_fill_flag     = fill_q;
    assign out_reject        = reject_q;
    assign out_solved        = solved_q;
    assign out_move_cnt      = move_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sudoku_entry_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sudoku_entry_ctrl
// Description : Directed self-checking bench for sudoku_entry_ctrl. Expected
//               board writes are queued as moves are entered and matched
//               against writes observed on the write port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sudoku_entry_ctrl;

    localparam int c_MOVE_W   = 8;
    localparam int c_CHECK_TO = 15;

    logic                in_clka;
    logic                in_restart_n;
    logic                in_new_game;
    logic                in_enter;
    logic [1:0]          in_diff_cell_val;
    logic                in_load_valid;
    logic [3:0]          in_load_idx;
    logic [2:0]          in_load_val;
    logic                in_load_done;
    logic                in_check_done;
    logic                in_check_pass;
    logic [3:0]          out_state;
    logic                out_set_diff_flag;
    logic                out_row_flag;
    logic                out_col_flag;
    logic                out_val_flag;
    logic                out_check_flag;
    logic [1:0]          out_diff;
    logic                out_wr_en;
    logic [3:0]          out_wr_idx;
    logic [2:0]          out_wr_val;
    logic [15:0]         out_fill_flag;
    logic                out_reject;
    logic                out_solved;
    logic [c_MOVE_W-1:0] out_move_cnt;

    int checks   = 0;
    int failures = 0;

    logic [6:0] exp_q[$];   // {idx, val} expected writes
    logic [6:0] obs_q[$];   // {idx, val} observed writes

    sudoku_entry_ctrl #(
        .MOVE_W   (c_MOVE_W),
        .CHECK_TO (c_CHECK_TO)
    ) dut (
        .in_clka           (in_clka),
        .in_restart_n      (in_restart_n),
        .in_new_game       (in_new_game),
        .in_enter          (in_enter),
        .in_diff_cell_val  (in_diff_cell_val),
        .in_load_valid     (in_load_valid),
        .in_load_idx       (in_load_idx),
        .in_load_val       (in_load_val),
        .in_load_done      (in_load_done),
        .in_check_done     (in_check_done),
        .in_check_pass     (in_check_pass),
        .out_state         (out_state),
        .out_set_diff_flag (out_set_diff_flag),
        .out_row_flag      (out_row_flag),
        .out_col_flag      (out_col_flag),
        .out_val_flag      (out_val_flag),
        .out_check_flag    (out_check_flag),
        .out_diff          (out_diff),
        .out_wr_en         (out_wr_en),
        .out_wr_idx        (out_wr_idx),
        .out_wr_val        (out_wr_val),
        .out_fill_flag     (out_fill_flag),
        .out_reject        (out_reject),
        .out_solved        (out_solved),
        .out_move_cnt      (out_move_cnt)
    );

    initial in_clka = 1'b0;
    always #5 in_clka = ~in_clka;

    // Write-port monitor, sampled mid-cycle.
    always @(negedge in_clka) begin
        if (in_restart_n && out_wr_en) begin
            obs_q.push_back({out_wr_idx, out_wr_val});
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input string tag);
        if (obs_q.size() == 0 || exp_q.size() == 0) begin
            chk({tag, "_avail"}, 32'(obs_q.size()), 32'(exp_q.size()));
        end else begin
            chk(tag, 32'(obs_q.pop_front()), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic tick();
        @(posedge in_clka);
        #1;
    endtask

    task automatic press(input logic [1:0] sel);
        in_enter         = 1'b1;
        in_diff_cell_val = sel;
        tick();
        in_enter         = 1'b0;
    endtask

    task automatic new_game();
        in_new_game = 1'b1;
        tick();
        in_new_game = 1'b0;
    endtask

    task automatic load(input logic [3:0] idx, input logic [2:0] val, input logic done);
        in_load_valid = 1'b1;
        in_load_idx   = idx;
        in_load_val   = val;
        in_load_done  = done;
        tick();
        in_load_valid = 1'b0;
        in_load_done  = 1'b0;
    endtask

    // New game with cells 1..15 fixed; cell 0 is loaded then cleared so it
    // stays playable. The last load coincides with load_done.
    task automatic start_full_game();
        new_game();
        press(2'd1);
        load(4'd0, 3'd2, 1'b0);
        load(4'd0, 3'd0, 1'b0);
        for (int i = 1; i < 16; i++) begin
            load(4'(i), 3'((i % 4) + 1), (i == 15));
        end
    endtask

    // Enter a move on row/col with value sel+1, queueing the expected write.
    task automatic play(input logic [1:0] row, input logic [1:0] col, input logic [1:0] sel);
        press(row);
        press(col);
        exp_q.push_back({row, col, 3'({1'b0, sel}) + 3'd1});
        press(sel);
    endtask

    initial begin
        int n;
        in_restart_n     = 1'b0;
        in_new_game      = 1'b0;
        in_enter         = 1'b0;
        in_diff_cell_val = 2'd0;
        in_load_valid    = 1'b0;
        in_load_idx      = 4'd0;
        in_load_val      = 3'd0;
        in_load_done     = 1'b0;
        in_check_done    = 1'b0;
        in_check_pass    = 1'b0;

        // Reset state
        #3;
        chk("rst_state", 32'(out_state), 0);
        chk("rst_fill", 32'(out_fill_flag), 0);
        chk("rst_move", 32'(out_move_cnt), 0);
        chk("rst_wr_en", 32'(out_wr_en), 0);
        tick();
        tick();
        in_restart_n = 1'b1;
        tick();
        chk("idle_state", 32'(out_state), 0);
        chk("idle_sdflag", 32'(out_set_diff_flag), 0);

        // New game and difficulty select
        new_game();
        chk("ng_state", 32'(out_state), 1);
        chk("ng_sdflag", 32'(out_set_diff_flag), 1);
        press(2'd2);
        chk("diff_state", 32'(out_state), 2);
        chk("diff_val", 32'(out_diff), 2);
        chk("diff_sdflag", 32'(out_set_diff_flag), 0);

        // Setup with one fixed cell
        load(4'd5, 3'd3, 1'b0);
        chk("load_fill", 32'(out_fill_flag), 32'h0020);
        chk("load_state", 32'(out_state), 2);
        in_load_done = 1'b1;
        tick();
        in_load_done = 1'b0;
        chk("done_state", 32'(out_state), 3);
        chk("done_rowflag", 32'(out_row_flag), 1);

        // Fixed-cell reject
        press(2'd1);
        chk("col_state", 32'(out_state), 4);
        press(2'd1);
        chk("val_state", 32'(out_state), 5);
        chk("val_flag", 32'(out_val_flag), 1);
        press(2'd0);
        chk("rej_pulse", 32'(out_reject), 1);
        chk("rej_state", 32'(out_state), 3);
        chk("rej_wr_en", 32'(out_wr_en), 0);
        chk("rej_move", 32'(out_move_cnt), 0);
        tick();
        chk("rej_end", 32'(out_reject), 0);
        chk("rej_nowrite", 32'(obs_q.size()), 0);

        // Legal move row 3 col 2 value 4
        play(2'd3, 2'd2, 2'd3);
        chk("wr_state", 32'(out_state), 6);
        chk("wr_en", 32'(out_wr_en), 1);
        chk("wr_idx", 32'(out_wr_idx), 14);
        chk("wr_val", 32'(out_wr_val), 4);
        tick();
        chk("mv_state", 32'(out_state), 3);
        chk("mv_wr_en", 32'(out_wr_en), 0);
        chk("mv_fill", 32'(out_fill_flag), 32'h4020);
        chk("mv_cnt", 32'(out_move_cnt), 1);
        sb_pop("sb_move1");

        // Fill the board and solve
        start_full_game();
        chk("full_state", 32'(out_state), 3);
        chk("full_fill", 32'(out_fill_flag), 32'hFFFE);
        chk("full_move", 32'(out_move_cnt), 0);
        play(2'd0, 2'd0, 2'd0);
        tick();
        chk("chk_state", 32'(out_state), 7);
        chk("chk_flag", 32'(out_check_flag), 1);
        chk("chk_fill", 32'(out_fill_flag), 32'hFFFF);
        chk("chk_move", 32'(out_move_cnt), 1);
        sb_pop("sb_move_idx0");
        tick();
        tick();
        in_check_done = 1'b1;
        in_check_pass = 1'b1;
        tick();
        in_check_done = 1'b0;
        in_check_pass = 1'b0;
        chk("solv_state", 32'(out_state), 8);
        chk("solv_flag", 32'(out_solved), 1);
        chk("solv_chkflag", 32'(out_check_flag), 0);
        press(2'd1);
        chk("solv_enter_state", 32'(out_state), 8);
        chk("solv_held", 32'(out_solved), 1);

        // Check fail, then timeout
        start_full_game();
        chk("ng2_solved", 32'(out_solved), 0);
        play(2'd0, 2'd0, 2'd1);
        tick();
        sb_pop("sb_move_fail");
        chk("chk2_state", 32'(out_state), 7);
        in_check_done = 1'b1;
        in_check_pass = 1'b0;
        tick();
        in_check_done = 1'b0;
        chk("fail_state", 32'(out_state), 3);
        chk("fail_fill", 32'(out_fill_flag), 32'hFFFF);
        chk("fail_solved", 32'(out_solved), 0);
        play(2'd0, 2'd0, 2'd2);
        tick();
        sb_pop("sb_refill");
        chk("chk3_state", 32'(out_state), 7);
        n = 0;
        while (out_state == 4'd7 && n < 40) begin
            tick();
            n++;
        end
        chk("to_len_ok", 32'((n >= c_CHECK_TO) && (n <= c_CHECK_TO + 1)), 1);
        chk("to_reject", 32'(out_reject), 1);
        chk("to_state", 32'(out_state), 3);
        chk("to_move", 32'(out_move_cnt), 2);

        // new_game beats enter in VAL
        press(2'd1);
        press(2'd1);
        chk("ab_val_state", 32'(out_state), 5);
        in_new_game = 1'b1;
        in_enter    = 1'b1;
        tick();
        in_new_game = 1'b0;
        in_enter    = 1'b0;
        chk("ab_state", 32'(out_state), 1);
        chk("ab_move", 32'(out_move_cnt), 0);
        chk("ab_fill", 32'(out_fill_flag), 0);
        chk("ab_wr_en", 32'(out_wr_en), 0);
        tick();
        chk("ab_nowrite", 32'(obs_q.size()), 0);

        // Asynchronous reset mid-CHECK
        start_full_game();
        play(2'd0, 2'd0, 2'd3);
        tick();
        sb_pop("sb_move_rst");
        chk("rst_chk_state", 32'(out_state), 7);
        tick();
        #2;
        in_restart_n = 1'b0;
        #1;
        chk("arst_state", 32'(out_state), 0);
        chk("arst_chkflag", 32'(out_check_flag), 0);
        chk("arst_fill", 32'(out_fill_flag), 0);
        chk("arst_move", 32'(out_move_cnt), 0);
        chk("arst_diff", 32'(out_diff), 0);
        chk("arst_solved", 32'(out_solved), 0);
        chk("sb_exp_empty", 32'(exp_q.size()), 0);
        chk("sb_obs_empty", 32'(obs_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sudoku_entry_ctrl.md
Name: sudoku_entry_ctrl

Overview:
- Sequences one 4x4 Sudoku game session.
- Flow: difficulty select, then board-setup intake from the generator, then row/col/value move entry, then the solution check handshake.
- Owns the fixed-cell mask and fill flags. Issues single-cycle write commands to the user-board storage. Sits between the button inputs and the board/check datapath.

Parameters:
- MOVE_W, 8: width of the saturating move counter.
- CHECK_TO, 15: cycles allowed in CHECK for in_check_done before timeout (1..255).

Ports:
- in_clka  in  1  clock, rising edge.
- in_restart_n  in  1  asynchronous active-low reset.
- in_new_game  in  1  start/abort game.
- in_enter  in  1  confirm current field (one-cycle pulse per press).
- in_diff_cell_val  in  2  difficulty / row / col / value-minus-1 selector.
- in_load_valid  in  1  generator setup write strobe.
- in_load_idx  in  4  setup cell index.
- in_load_val  in  3  setup value; 0 means empty.
- in_load_done  in  1  generator finished setup.
- in_check_done  in  1  checker result valid.
- in_check_pass  in  1  checker result; qualified by in_check_done.
- out_state  out  4  current state encoding.
- out_set_diff_flag, out_row_flag, out_col_flag, out_val_flag, out_check_flag  out  1 each  high while in SET_DIFF / ROW / COL / VAL / CHECK.
- out_diff  out  2  latched difficulty.
- out_wr_en  out  1  user-board write strobe.
- out_wr_idx  out  4  write index (row*4+col).
- out_wr_val  out  3  write value, 1..4.
- out_fill_flag  out  16  bit i set means cell i holds a value.
- out_reject  out  1  one-cycle pulse: move refused or check timed out.
- out_solved  out  1  game solved.
- out_move_cnt  out  MOVE_W  accepted user moves.

Behaviour:
- Reset: all registered outputs 0, state IDLE(0), fixed mask 0, row/col 0. Reset is asynchronous; it aborts any state including mid-CHECK.
- State encodings: IDLE=0, SET_DIFF=1, WAIT_LOAD=2, ROW=3, COL=4, VAL=5, WRITE=6, CHECK=7, SOLVED=8. All outputs are registered; flags reflect the current state.
- in_new_game priority: it has highest priority in every state, over in_enter, in_load_valid and in_check_done. Next state is SET_DIFF. It clears move_cnt, fill_flag, the fixed mask and out_solved.
- IDLE: waits for in_new_game.
- SET_DIFF: in_enter latches out_diff=in_diff_cell_val, then goes to WAIT_LOAD.
- WAIT_LOAD:
  - Each in_load_valid with in_load_val!=0 sets fixed[idx] and fill[idx]. A zero value clears both.
  - in_load_done goes to ROW. If in_load_valid and in_load_done arrive in the same cycle, the write is applied, then the state goes to ROW.
- ROW: in_enter latches row, then COL.
- COL: in_enter latches col, then VAL.
- VAL, on in_enter:
  - If fixed[row*4+col]: pulse out_reject next cycle, no write, move_cnt unchanged, back to ROW.
  - Otherwise: WRITE with value in_diff_cell_val+1.
- WRITE (exactly 1 cycle):
  - out_wr_en=1 with out_wr_idx/out_wr_val.
  - Set fill[idx] and increment move_cnt, saturating at 2^MOVE_W-1.
  - Overwriting an already-filled user cell is legal and counts as a move.
  - Next state: CHECK if the updated fill_flag equals 16'hFFFF, else ROW.
- CHECK:
  - Timer loads 0 on entry and increments each cycle.
  - in_check_done with in_check_pass=1 goes to SOLVED.
  - in_check_done with in_check_pass=0 goes to ROW; the board stays full so the user can overwrite cells.
  - If the timer reaches CHECK_TO without done: pulse out_reject, go to ROW.
  - A done arriving on the timeout cycle wins over the timeout.
- SOLVED: out_solved=1 and held. in_enter is ignored; only in_new_game leaves.
- in_enter is ignored in IDLE, WAIT_LOAD, WRITE and CHECK.
- Load strobes outside WAIT_LOAD are ignored. Check strobes outside CHECK are ignored.
- Latency: enter in VAL produces out_wr_en 1 cycle later (WRITE state registered); CHECK is entered the cycle after WRITE.

Test Plan:
- Reset then new_game: release in_restart_n, pulse in_new_game, enter with sel=2 -> out_state 1 then 2; out_diff=2; out_set_diff_flag high only in state 1.
- Fixed-cell reject: load idx5 val3, done. Then enter row=1, col=1, val=0 -> out_reject pulse, no out_wr_en, move_cnt=0, back to state 3.
- Legal move: load idx5 only. Enter row=3, col=2, val=3 -> out_wr_en 1 cycle, idx=14, val=4; fill[14]=1; move_cnt=1; state 3.
- Fill and solve: load 15 cells, play idx0 -> state 7, out_check_flag=1. Then check_done+pass -> state 8, out_solved=1. An enter afterwards is ignored.
- Check fail and timeout: check_done with pass=0 -> state 3, fill stays FFFF. Refill a cell and give no done for 15 cycles -> out_reject, state 3.
- Aborts: in_new_game in state 5 with in_enter same cycle -> state 1, move_cnt=0, fill=0. Assert in_restart_n low mid-CHECK -> all outputs 0 immediately.
